// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scan controller.
package keypad_pkg;

  // Debounce states, evaluated once per completed sweep
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAND = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } deb_state_e;

  // Scanner column one-hot encodings; E is the last column of a sweep
  localparam logic [2:0] COL_C = 3'b001;
  localparam logic [2:0] COL_A = 3'b010;
  localparam logic [2:0] COL_E = 3'b100;

  // Code the scanner reports when nothing is pressed
  localparam logic [3:0] KEY_NONE = 4'd13;

  // True when the column bus carries exactly one of the legal columns
  function automatic logic col_onehot(input logic [2:0] c);
    return (c == COL_C) || (c == COL_A) || (c == COL_E);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small key-code FIFO: registered storage, head visible while non-empty.
module key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [3:0]                 din_i,
  output logic [3:0]                 dout_o,
  output logic [$clog2(DEPTH):0]     cnt_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop, do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  // A pop frees the slot, so a push into a full FIFO is accepted alongside it
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? 4'd0 : mem_q[rd_q];
  assign cnt_o   = cnt_q;

  // Storage array; contents are meaningless until written, so no reset
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointers wrap naturally at power-of-two depth; count tracks occupancy
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan controller: column tick divider, sweep sampler, debounce
// FSM and a key FIFO read by the MCU.
module keypad_scan_ctrl import keypad_pkg::*; #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_SWEEPS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [2:0]                    COL,
  input  logic                          KEY_PRESS,
  input  logic [3:0]                    KEY_DATA,
  output logic                          SCAN_EN,
  output logic                          KEY_VALID,
  output logic [3:0]                    KEY_CODE,
  input  logic                          RD_ACK,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_CNT,
  output logic                          OVF,
  input  logic                          CLR_OVF
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_SWEEPS + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_SWEEPS);

  logic [DW-1:0] div_q;
  logic          sweep_p_q;
  logic [3:0]    sweep_code_q;
  deb_state_e    state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          col_ok, eval, res_p;
  logic [3:0]    res_code;
  logic          push, fifo_full, fifo_empty, ovf_set;

  assign SCAN_EN = (div_q == DW'(SCAN_DIV - 1));

  // Free-running divider; terminal count produces the column tick
  always_ff @(posedge CLK) begin
    if (!RST_N)       div_q <= '0;
    else if (SCAN_EN) div_q <= '0;
    else              div_q <= div_q + DW'(1);
  end

  // The E-column sample closes the sweep; fold it into the result directly
  assign col_ok   = col_onehot(COL);
  assign eval     = SCAN_EN && col_ok && COL[2];
  assign res_p    = sweep_p_q | KEY_PRESS;
  assign res_code = sweep_p_q ? sweep_code_q : KEY_DATA;

  // Sweep accumulator: first pressed sample wins, cleared at sweep end or on a bad column
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sweep_p_q    <= 1'b0;
      sweep_code_q <= 4'd0;
    end else if (SCAN_EN) begin
      if (!col_ok || COL[2]) begin
        sweep_p_q    <= 1'b0;
        sweep_code_q <= 4'd0;
      end else begin
        if (KEY_PRESS && !sweep_p_q) sweep_code_q <= KEY_DATA;
        sweep_p_q <= sweep_p_q | KEY_PRESS;
      end
    end
  end

  assign cnt_inc = (cnt_q >= DEB_MAX) ? cnt_q : cnt_q + CW'(1);

  // Debounce next-state: only a completed sweep moves the FSM
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (eval) begin
      case (state_q)
        IDLE: if (res_p) begin
          cand_d = res_code;
          cnt_d  = CW'(1);
          if (DEB_SWEEPS == 1) begin
            push    = 1'b1;
            state_d = HELD;
          end else begin
            state_d = CAND;
          end
        end
        CAND: if (res_p && res_code == cand_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_MAX) begin
            push    = 1'b1;
            state_d = HELD;
          end
        end else if (res_p) begin
          cand_d = res_code;
          cnt_d  = CW'(1);
        end else begin
          state_d = IDLE;
        end
        HELD: if (!res_p) begin
          cnt_d   = CW'(1);
          state_d = (DEB_SWEEPS == 1) ? IDLE : REL;
        end
        REL: if (!res_p) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_MAX) state_d = IDLE;
        end else begin
          state_d = HELD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Debounce state registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pushed code is the sweep result; it equals cand in every pushing transition
  key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .push_i  (push),
    .pop_i   (RD_ACK),
    .din_i   (res_code),
    .dout_o  (KEY_CODE),
    .cnt_o   (FIFO_CNT),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign KEY_VALID = !fifo_empty;
  assign ovf_set   = push && fifo_full && !(RD_ACK && !fifo_empty);

  // Sticky overflow; a new drop takes precedence over a clear
  always_ff @(posedge CLK) begin
    if (!RST_N)       OVF <= 1'b0;
    else if (ovf_set) OVF <= 1'b1;
    else if (CLR_OVF) OVF <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: sweep-level reference model plus directed scenarios.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int SD  = 4;
  localparam int DEB = 2;
  localparam int FD  = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] COL = COL_C;
  logic       KEY_PRESS = 1'b0;
  logic [3:0] KEY_DATA = KEY_NONE;
  logic       RD_ACK = 1'b0;
  logic       CLR_OVF = 1'b0;
  logic       SCAN_EN, KEY_VALID, OVF;
  logic [3:0] KEY_CODE;
  logic [2:0] FIFO_CNT;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEB_SWEEPS(DEB), .FIFO_DEPTH(FD)) dut (
    .CLK(CLK), .RST_N(RST_N), .COL(COL), .KEY_PRESS(KEY_PRESS), .KEY_DATA(KEY_DATA),
    .SCAN_EN(SCAN_EN), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE), .RD_ACK(RD_ACK),
    .FIFO_CNT(FIFO_CNT), .OVF(OVF), .CLR_OVF(CLR_OVF)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit         m_ok = 1'b0;
  int         m_cyc;
  bit         m_accp;
  logic [3:0] m_accc;
  int         m_run, m_rel;
  logic [3:0] m_last;
  bit         m_held;
  logic [3:0] m_q[$];
  bit         m_ovf;

  // A press is accepted after DEB identical pressed sweeps, released after DEB empty sweeps
  task automatic m_sweep(input bit p, input logic [3:0] code, output bit push, output logic [3:0] pc);
    push = 1'b0;
    pc   = code;
    if (!m_held) begin
      if (p) begin
        if (m_run > 0 && code == m_last) m_run++;
        else m_run = 1;
        m_last = code;
        if (m_run >= DEB) begin
          push   = 1'b1;
          m_held = 1'b1;
          m_rel  = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (p) begin
      m_rel = 0;
    end else begin
      m_rel++;
      if (m_rel >= DEB) begin
        m_held = 1'b0;
        m_run  = 0;
      end
    end
  endtask

  always @(posedge CLK) begin
    bit         push, scan, pop, ovf_set;
    logic [3:0] pc;
    if (!RST_N) begin
      m_cyc = 0; m_accp = 0; m_accc = 0; m_run = 0; m_rel = 0;
      m_held = 0; m_last = 0; m_q.delete(); m_ovf = 0; m_ok = 1;
    end else if (m_ok) begin
      push = 0; pc = 0; ovf_set = 0;
      scan = (m_cyc == SD - 1);
      if (scan) begin
        if (!(COL == COL_C || COL == COL_A || COL == COL_E)) begin
          m_accp = 0;
        end else begin
          if (KEY_PRESS && !m_accp) m_accc = KEY_DATA;
          m_accp = m_accp | KEY_PRESS;
          if (COL == COL_E) begin
            m_sweep(m_accp, m_accc, push, pc);
            m_accp = 0;
          end
        end
      end
      pop = RD_ACK && (m_q.size() > 0);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < FD) m_q.push_back(pc);
        else ovf_set = 1;
      end
      if (ovf_set) m_ovf = 1;
      else if (CLR_OVF) m_ovf = 0;
      m_cyc = scan ? 0 : m_cyc + 1;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge CLK) begin
    if (m_ok) begin
      chk("scan_en",   32'(SCAN_EN),   32'(m_cyc == SD - 1));
      chk("key_valid", 32'(KEY_VALID), 32'(m_q.size() > 0));
      chk("fifo_cnt",  32'(FIFO_CNT),  32'(m_q.size()));
      chk("ovf",       32'(OVF),       32'(m_ovf));
      if (m_q.size() > 0) chk("key_code", 32'(KEY_CODE), 32'(m_q[0]));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present one column until its tick has been sampled; optional ack in the tick cycle
  task automatic col_step(input logic [2:0] c, input logic p, input logic [3:0] d, input logic ack);
    int k = 0;
    COL = c;
    KEY_PRESS = p;
    KEY_DATA = p ? d : KEY_NONE;
    while (SCAN_EN !== 1'b1 && k < 2 * SD) begin
      @(negedge CLK);
      k++;
    end
    if (SCAN_EN !== 1'b1) chk("scan_wait", 32'(SCAN_EN), 32'd1);
    RD_ACK = ack;
    @(negedge CLK);
    RD_ACK = 1'b0;
  endtask

  // colsel: 0=C, 1=A, 2=E, 3=no key
  task automatic sweep(input int colsel, input logic [3:0] code, input logic ack);
    col_step(COL_C, colsel == 0, code, 1'b0);
    col_step(COL_A, colsel == 1, code, 1'b0);
    col_step(COL_E, colsel == 2, code, ack);
  endtask

  task automatic press_release(input int colsel, input logic [3:0] code);
    sweep(colsel, code, 1'b0);
    sweep(colsel, code, 1'b0);
    sweep(3, 4'd0, 1'b0);
    sweep(3, 4'd0, 1'b0);
  endtask

  task automatic pop();
    RD_ACK = 1'b1;
    @(negedge CLK);
    RD_ACK = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    int k;
    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_scan_en",   32'(SCAN_EN),   32'd0);
    chk("rst_key_valid", 32'(KEY_VALID), 32'd0);
    chk("rst_key_code",  32'(KEY_CODE),  32'd0);
    chk("rst_fifo_cnt",  32'(FIFO_CNT),  32'd0);
    chk("rst_ovf",       32'(OVF),       32'd0);
    RST_N = 1'b1;
    k = 0;
    while (SCAN_EN !== 1'b1 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("first_scan_delay", 32'(k), 32'd3);
    @(negedge CLK);

    // 1: idle sweeps
    repeat (10) sweep(3, 4'd0, 1'b0);
    chk("s1_cnt", 32'(FIFO_CNT), 32'd0);

    // 2: key 5 on column A, 5 sweeps held then 3 released
    sweep(1, 4'd5, 1'b0);
    chk("s2_valid_early", 32'(KEY_VALID), 32'd0);
    sweep(1, 4'd5, 1'b0);
    chk("s2_valid", 32'(KEY_VALID), 32'd1);
    chk("s2_code",  32'(KEY_CODE),  32'd5);
    repeat (3) sweep(1, 4'd5, 1'b0);
    repeat (3) sweep(3, 4'd0, 1'b0);
    chk("s2_cnt", 32'(FIFO_CNT), 32'd1);
    pop();
    chk("s2_empty", 32'(KEY_VALID), 32'd0);

    // 3: bounce
    sweep(0, 4'd7, 1'b0);
    sweep(3, 4'd0, 1'b0);
    sweep(0, 4'd7, 1'b0);
    chk("s3_cnt_mid", 32'(FIFO_CNT), 32'd0);
    sweep(0, 4'd7, 1'b0);
    chk("s3_cnt",  32'(FIFO_CNT), 32'd1);
    chk("s3_code", 32'(KEY_CODE), 32'd7);
    repeat (2) sweep(3, 4'd0, 1'b0);
    pop();

    // 4: two presses queued, then read out
    press_release(0, 4'd1);
    press_release(2, 4'd11);
    chk("s4_cnt",   32'(FIFO_CNT), 32'd2);
    chk("s4_code1", 32'(KEY_CODE), 32'd1);
    pop();
    chk("s4_code2", 32'(KEY_CODE), 32'd11);
    pop();
    chk("s4_empty", 32'(KEY_VALID), 32'd0);

    // 5: overflow, clear, then pop+push while full
    press_release(0, 4'd2);
    press_release(1, 4'd3);
    press_release(2, 4'd4);
    press_release(0, 4'd6);
    press_release(1, 4'd8);
    chk("s5_cnt",  32'(FIFO_CNT), 32'd4);
    chk("s5_ovf",  32'(OVF),      32'd1);
    chk("s5_head", 32'(KEY_CODE), 32'd2);
    CLR_OVF = 1'b1;
    @(negedge CLK);
    CLR_OVF = 1'b0;
    chk("s5_ovf_clr", 32'(OVF), 32'd0);
    sweep(1, 4'd9, 1'b0);
    sweep(1, 4'd9, 1'b1);
    chk("s5_pp_cnt",  32'(FIFO_CNT), 32'd4);
    chk("s5_pp_ovf",  32'(OVF),      32'd0);
    chk("s5_pp_head", 32'(KEY_CODE), 32'd3);
    repeat (2) sweep(3, 4'd0, 1'b0);
    pop();
    chk("s5_pop_a", 32'(KEY_CODE), 32'd4);
    pop();
    chk("s5_pop_b", 32'(KEY_CODE), 32'd6);
    pop();
    chk("s5_pop_c", 32'(KEY_CODE), 32'd9);

    // 6: corrupted sweep, then reset during CAND with a key still queued
    sweep(1, 4'd10, 1'b0);
    col_step(COL_C, 1'b1, 4'd10, 1'b0);
    col_step(3'b011, 1'b1, 4'd10, 1'b0);
    col_step(COL_E, 1'b0, 4'd0, 1'b0);
    chk("s6_no_push", 32'(FIFO_CNT), 32'd1);
    sweep(1, 4'd10, 1'b0);
    col_step(COL_C, 1'b1, 4'd10, 1'b0);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("s6_rst_scan_en",   32'(SCAN_EN),   32'd0);
    chk("s6_rst_key_valid", 32'(KEY_VALID), 32'd0);
    chk("s6_rst_key_code",  32'(KEY_CODE),  32'd0);
    chk("s6_rst_fifo_cnt",  32'(FIFO_CNT),  32'd0);
    chk("s6_rst_ovf",       32'(OVF),       32'd0);
    RST_N = 1'b1;
    sweep(1, 4'd10, 1'b0);
    chk("s6_idle_after_rst", 32'(FIFO_CNT), 32'd0);
    sweep(1, 4'd10, 1'b0);
    chk("s6_push_cnt",  32'(FIFO_CNT), 32'd1);
    chk("s6_push_code", 32'(KEY_CODE), 32'd10);

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
